// File: rtl/sub_share_arbiter_if.sv
// sub_share_arbiter_if
//   Bundles the request/operand/response signals between the requesters
//   (master side) and the shared subtractor arbiter (slave side).
//
//   req        NREQ        per-requester request level
//   a_bus      NREQ*WIDTH  minuends, requester i at [i*WIDTH +: WIDTH]
//   b_bus      NREQ*WIDTH  subtrahends, same packing
//   ack        NREQ        one-hot, one-cycle completion pulse
//   diff       WIDTH       registered a-b of the served request
//   diff_valid 1           high for the ack cycle only
//   grant_id   IDW         id of the requester being served
//   busy       1           operation in flight
//   borrow     1           a<b of the served request (SUB_ARB_BORROW_EN only)
//
// Optional feature macro: SUB_ARB_BORROW_EN
interface sub_share_arbiter_if #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      diff;
    logic                  diff_valid;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
`ifdef SUB_ARB_BORROW_EN
    logic                  borrow;

    modport master (
        output req, a_bus, b_bus,
        input  ack, diff, diff_valid, grant_id, busy, borrow
    );
    modport slave (
        input  req, a_bus, b_bus,
        output ack, diff, diff_valid, grant_id, busy, borrow
    );
`else
    modport master (
        output req, a_bus, b_bus,
        input  ack, diff, diff_valid, grant_id, busy
    );
    modport slave (
        input  req, a_bus, b_bus,
        output ack, diff, diff_valid, grant_id, busy
    );
`endif
endinterface

// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter
//   Shares one WIDTH-bit subtractor among NREQ requesters with round-robin
//   arbitration. The winner's operands are latched at the grant edge, the
//   difference is registered one cycle later, and a one-cycle ack/diff_valid
//   is returned to the served requester only.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sub_share_arbiter_if.slave (req, a_bus, b_bus in;
//          ack, diff, diff_valid, grant_id, busy [, borrow] out)
//
// Optional feature macro: SUB_ARB_BORROW_EN adds registered borrow (a<b).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for any req; grant and operand latch on exit
//   EXEC  | subtract latched operands into diff
//   RESP  | ack/diff_valid to grant_id, advance round-robin pointer
module sub_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sub_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   grant_q;
    logic [IDW-1:0]   win;
    logic             any_req;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] diff_q;
`ifdef SUB_ARB_BORROW_EN
    logic             borrow_q;
`endif

    assign any_req = |bus.req;

    // Circular search from ptr_q upward. Walking the offsets from highest to
    // lowest lets the closest set bit overwrite any farther one.
    always_comb begin : rr_search
        logic [IDW:0] idx;
        win = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            if (bus.req[idx[IDW-1:0]]) begin
                win = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack        = '0;
        bus.diff_valid = 1'b0;
        bus.busy       = 1'b0;
        case (state_q)
            EXEC: bus.busy = 1'b1;
            RESP: begin
                bus.busy       = 1'b1;
                bus.diff_valid = 1'b1;
                bus.ack        = NREQ'(1) << grant_q;
            end
            default: ;
        endcase
    end

    // Datapath registers: operand latch, result, grant id and pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            grant_q  <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            diff_q   <= '0;
`ifdef SUB_ARB_BORROW_EN
            borrow_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= win;
                        a_lat   <= bus.a_bus[int'(win)*WIDTH +: WIDTH];
                        b_lat   <= bus.b_bus[int'(win)*WIDTH +: WIDTH];
                    end
                end
                EXEC: begin
                    diff_q   <= a_lat - b_lat;
`ifdef SUB_ARB_BORROW_EN
                    borrow_q <= (a_lat < b_lat);
`endif
                end
                RESP: begin
                    if (grant_q == IDW'(NREQ - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= grant_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff     = diff_q;
    assign bus.grant_id = grant_q;
`ifdef SUB_ARB_BORROW_EN
    assign bus.borrow   = borrow_q;
`endif

endmodule

// File: tb/tb_sub_share_arbiter.sv
module tb_sub_share_arbiter;
    localparam int WIDTH = 64;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sub_share_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    sub_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level reference: a grant at edge g fixes the whole
    // transaction; result visible from g+1, ack during the cycle after g+1,
    // pointer advances at g+2, next grant possible from g+3.
    int               e = 0;
    bit               m_active;
    int               m_g;
    int               m_gid;
    int               m_ptr;
    logic [WIDTH-1:0] m_a, m_b;
    logic [WIDTH-1:0] e_diff;
    logic [IDW-1:0]   e_gid;
    bit               e_borrow;
    bit               auto_drop;
    int               ack_id_q[$];
    int               ack_e_q[$];

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_g      = -10;
        m_ptr    = 0;
        e_diff   = '0;
        e_gid    = '0;
        e_borrow = 0;
    endtask

    task automatic model_edge();
        e++;
        if (m_active && e == m_g + 1) begin
            e_diff   = m_a - m_b;
            e_borrow = (m_a < m_b);
        end
        if (m_active && e == m_g + 2) m_ptr = (m_gid + 1) % NREQ;
        if ((!m_active || e >= m_g + 3) && bus.req != '0) begin
            m_active = 1;
            m_g      = e;
            m_gid    = rr_pick(bus.req, m_ptr);
            m_a      = bus.a_bus[m_gid*WIDTH +: WIDTH];
            m_b      = bus.b_bus[m_gid*WIDTH +: WIDTH];
            e_gid    = IDW'(m_gid);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] x_ack;
        bit in_resp;
        bit busy_x;
        in_resp = m_active && (e - m_g == 1);
        busy_x  = m_active && (e - m_g <= 1) && rst_n;
        x_ack   = in_resp && rst_n ? NREQ'(1) << m_gid : '0;
        chk("ack", 64'(bus.ack), 64'(x_ack));
        chk("diff_valid", 64'(bus.diff_valid), 64'(in_resp && rst_n));
        chk("busy", 64'(bus.busy), 64'(busy_x));
        chk("diff", bus.diff, e_diff);
        chk("grant_id", 64'(bus.grant_id), 64'(e_gid));
`ifdef SUB_ARB_BORROW_EN
        chk("borrow", 64'(bus.borrow), 64'(e_borrow));
`endif
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.a_bus[i*WIDTH +: WIDTH] = a;
        bus.b_bus[i*WIDTH +: WIDTH] = b;
    endtask

    // One clock: model at the edge, check at the falling edge, then requesters
    // that see their ack drop req before the next edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) begin
                ack_id_q.push_back(i);
                ack_e_q.push_back(e);
            end
        end
        if (auto_drop) bus.req = bus.req & ~bus.ack;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        ack_id_q.delete();
        ack_e_q.delete();
    endtask

    initial begin
        bus.req   = '0;
        bus.a_bus = '0;
        bus.b_bus = '0;
        auto_drop = 1;
        model_reset();

        // reset state
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // single request
        set_op(0, 64'd10, 64'd3);
        bus.req = 4'b0001;
        step();
        chk("t1_gid", 64'(bus.grant_id), 64'd0);
        step();
        chk("t1_ack", 64'(bus.ack), 64'b0001);
        chk("t1_diff", bus.diff, 64'd7);
        step();
        chk("t1_idle", 64'(bus.busy), 64'd0);

        // all four from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(100 + i), WIDTH'(i));
        bus.req = 4'b1111;
        repeat (13) step();
        chk("t2_nacks", 64'(ack_id_q.size()), 64'd4);
        for (int i = 0; i < ack_id_q.size(); i++) begin
            chk("t2_order", 64'(ack_id_q[i]), 64'(i));
            if (i > 0) chk("t2_spacing", 64'(ack_e_q[i] - ack_e_q[i-1]), 64'd3);
        end
        chk("t2_req_dropped", 64'(bus.req), 64'd0);
        chk("t2_diff", bus.diff, 64'd100);

        // round-robin wrap
        do_reset();
        set_op(0, 64'd30, 64'd1);
        set_op(2, 64'd40, 64'd2);
        set_op(3, 64'd50, 64'd3);
        bus.req = 4'b0100;
        repeat (3) step();
        ack_id_q.delete();
        bus.req = 4'b0101;
        step();
        chk("t3_first_after2", 64'(bus.grant_id), 64'd0);
        repeat (5) step();
        chk("t3_nacks", 64'(ack_id_q.size()), 64'd2);
        if (ack_id_q.size() == 2) chk("t3_second", 64'(ack_id_q[1]), 64'd2);
        bus.req = 4'b1000;
        repeat (3) step();
        set_op(1, 64'd60, 64'd4);
        bus.req = 4'b1010;
        step();
        chk("t3_ptr0_after3", 64'(bus.grant_id), 64'd1);
        repeat (5) step();

        // wrap-around arithmetic
        set_op(2, 64'd0, 64'd1);
        bus.req = 4'b0100;
        step(); step();
        chk("t4_allones", bus.diff, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef SUB_ARB_BORROW_EN
        chk("t4_borrow1", 64'(bus.borrow), 64'd1);
`endif
        step();
        set_op(2, 64'd5, 64'd5);
        bus.req = 4'b0100;
        step(); step();
        chk("t4_zero", bus.diff, 64'd0);
`ifdef SUB_ARB_BORROW_EN
        chk("t4_borrow0", 64'(bus.borrow), 64'd0);
`endif
        step();

        // reset mid-operation
        do_reset();
        set_op(1, 64'd11, 64'd1);
        bus.req = 4'b0010;
        repeat (3) step();
        set_op(3, 64'd99, 64'd9);
        bus.req = 4'b1000;
        step();
        chk("t5_exec_busy", 64'(bus.busy), 64'd1);
        #1;
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        model_reset();
        check_all();
        chk("t5_diff_zero", bus.diff, 64'd0);
        ack_id_q.delete();
        repeat (3) begin
            @(negedge clk);
            check_all();
            chk("t5_no_ack", 64'(bus.ack), 64'd0);
        end
        rst_n = 1'b1;
        set_op(1, 64'd40, 64'd15);
        set_op(2, 64'd70, 64'd1);
        bus.req = 4'b0110;
        step();
        chk("t5_gid1", 64'(bus.grant_id), 64'd1);
        step();
        chk("t5_ack1", 64'(bus.ack), 64'b0010);
        chk("t5_diff", bus.diff, 64'd25);
        repeat (4) step();

        // operand change and req drop after grant
        auto_drop = 0;
        set_op(1, 64'd50, 64'd8);
        bus.req = 4'b0010;
        step();
        set_op(1, 64'd999, 64'd8);
        bus.req = '0;
        step();
        chk("t6_ack", 64'(bus.ack), 64'b0010);
        chk("t6_diff", bus.diff, 64'd42);
        step();
        auto_drop = 1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    logic [WIDTH-1:0] ra, rb;
                    ra = {$urandom, $urandom};
                    rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
                    if ($urandom_range(0, 7) == 0) ra = WIDTH'($urandom_range(0, 3));
                    set_op(i, ra, rb);
                    bus.req[i] = 1'b1;
                end
            end
            step();
        end
        repeat (20) step();
        chk("drain_req", 64'(bus.req), 64'd0);
        chk("drain_busy", 64'(bus.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
